// File: rtl/rf_sequencer_pkg.sv
// Shared definitions for the register-file instruction sequencer: opcodes,
// sequencer state encoding and valid_address strobe bit positions.
package rf_sequencer_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_LDI = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_EXEC  = 2'b10,
    ST_WRITE = 2'b11
  } state_e;

  // Bit positions inside valid_address
  localparam int VA_RD2 = 2;
  localparam int VA_RD1 = 1;
  localparam int VA_WR  = 0;

  localparam logic [2:0] VA_NONE  = 3'b000;
  localparam logic [2:0] VA_READ  = 3'((1 << VA_RD2) | (1 << VA_RD1));
  localparam logic [2:0] VA_WRITE = 3'(1 << VA_WR);

endpackage

// File: rtl/rf_sequencer_alu16.sv
// Combinational 16-bit ALU. LDI passes operand a through; the sequencer
// steers the immediate onto a for that opcode.
module alu16
  import rf_sequencer_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  // Opcode decode; shifts use only the low nibble of b, zero fill
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLL:  y = a << b[3:0];
      OP_SRL:  y = a >> b[3:0];
      OP_LDI:  y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rf_sequencer.sv
// Instruction sequencer in front of the 32x16 register file. Each accepted
// instruction walks IDLE -> READ -> EXEC -> WRITE -> IDLE with no overlap,
// so every register-file strobe is a registered function of the state and
// the instruction latched at accept.
module rf_sequencer
  import rf_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs,
  input  logic [ADDR_W-1:0] instr_rt,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [ADDR_W-1:0] read_address1,
  output logic [ADDR_W-1:0] read_address2,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  output logic [2:0]        valid_address,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  output logic              done,
  output logic [15:0]       retire_count
);

  state_e              state;
  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   rd_q;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_y;

  // LDI bypasses the register file: the latched immediate replaces operand a
  assign alu_a = (op_q == OP_LDI) ? imm_q : read_data1;

  alu16 u_alu (
    .op (op_q),
    .a  (alu_a),
    .b  (read_data2),
    .y  (alu_y)
  );

  // Sequencer FSM with registered register-file strobes and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      instr_ready   <= 1'b1;
      op_q          <= OP_ADD;
      rd_q          <= '0;
      imm_q         <= '0;
      read_address1 <= '0;
      read_address2 <= '0;
      write_address <= '0;
      write_data    <= '0;
      valid_address <= VA_NONE;
      done          <= 1'b0;
      retire_count  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (instr_valid && instr_ready) begin
            // The source addresses registers double as the rs/rt latches
            op_q          <= instr_op;
            rd_q          <= instr_rd;
            imm_q         <= instr_imm;
            read_address1 <= instr_rs;
            read_address2 <= instr_rt;
            valid_address <= (instr_op == OP_LDI) ? VA_NONE : VA_READ;
            instr_ready   <= 1'b0;
            state         <= ST_READ;
          end
        end
        ST_READ: begin
          valid_address <= VA_NONE;
          state         <= ST_EXEC;
        end
        ST_EXEC: begin
          // Operands are valid on read_data1/2 now; capture the result
          write_address <= rd_q;
          write_data    <= alu_y;
          valid_address <= VA_WRITE;
          done          <= 1'b1;
          state         <= ST_WRITE;
        end
        ST_WRITE: begin
          valid_address <= VA_NONE;
          done          <= 1'b0;
          retire_count  <= retire_count + 16'd1;
          instr_ready   <= 1'b1;
          state         <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_sequencer.sv
// Bench for rf_sequencer: a behavioural 32x16 register file with 20-unit
// output delay, a shadow register model and directed plus random programs.
module tb_rf_sequencer;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  instr_op;
  logic [4:0]  instr_rd;
  logic [4:0]  instr_rs;
  logic [4:0]  instr_rt;
  logic [15:0] instr_imm;
  logic [4:0]  read_address1;
  logic [4:0]  read_address2;
  logic [4:0]  write_address;
  logic [15:0] write_data;
  logic [2:0]  valid_address;
  logic [15:0] read_data1;
  logic [15:0] read_data2;
  logic        done;
  logic [15:0] retire_count;

  int checks = 0;
  int errors = 0;
  int unsigned retired = 0;

  logic [15:0] mem   [32];
  logic [15:0] model [32];

  rf_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_op      (instr_op),
    .instr_rd      (instr_rd),
    .instr_rs      (instr_rs),
    .instr_rt      (instr_rt),
    .instr_imm     (instr_imm),
    .read_address1 (read_address1),
    .read_address2 (read_address2),
    .write_address (write_address),
    .write_data    (write_data),
    .valid_address (valid_address),
    .read_data1    (read_data1),
    .read_data2    (read_data2),
    .done          (done),
    .retire_count  (retire_count)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Register file: samples reads and writes on the edge, outputs 20 later
  always @(posedge clk) begin : rf_port
    logic        v1, v2;
    logic [15:0] c1, c2;
    v1 = valid_address[1];
    v2 = valid_address[2];
    c1 = mem[read_address1];
    c2 = mem[read_address2];
    if (valid_address[0]) mem[write_address] = write_data;
    #20;
    if (v1) read_data1 = c1;
    if (v2) read_data2 = c2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result from plain arithmetic on unsigned integers
  function automatic logic [15:0] ref_result(input logic [2:0] op, input logic [15:0] a,
                                             input logic [15:0] b, input logic [15:0] imm);
    int unsigned ai, bi, sh, r;
    ai = a;
    bi = b;
    sh = bi % 16;
    case (op)
      3'd0:    r = ai + bi;
      3'd1:    r = ai + 65536 - bi;
      3'd2:    r = ai & bi;
      3'd3:    r = ai | bi;
      3'd4:    r = ai ^ bi;
      3'd5:    r = ai * (32'd1 << sh);
      3'd6:    r = ai / (32'd1 << sh);
      default: r = imm;
    endcase
    return 16'(r % 65536);
  endfunction

  // Issue one instruction and follow it cycle by cycle to writeback
  task automatic run_instr(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [15:0] imm, input bit hold,
                           input string tag);
    logic [15:0] exp;
    @(negedge clk);
    check({tag, ".ready_idle"}, instr_ready, 1);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_rd    = rd;
    instr_rs    = rs;
    instr_rt    = rt;
    instr_imm   = imm;
    exp = ref_result(op, model[rs], model[rt], imm);
    @(posedge clk); #1;
    if (!hold) instr_valid = 1'b0;
    else begin
      instr_op  = 3'($urandom);
      instr_rd  = 5'($urandom);
      instr_rs  = 5'($urandom);
      instr_rt  = 5'($urandom);
      instr_imm = 16'($urandom);
    end
    check({tag, ".ready_read"}, instr_ready, 0);
    check({tag, ".va_read"}, valid_address, (op == 3'd7) ? 3'b000 : 3'b110);
    if (op != 3'd7) begin
      check({tag, ".ra1"}, read_address1, rs);
      check({tag, ".ra2"}, read_address2, rt);
    end
    @(posedge clk); #1;
    check({tag, ".va_exec"}, valid_address, 3'b000);
    check({tag, ".done_exec"}, done, 0);
    @(posedge clk); #1;
    check({tag, ".done_wr"}, done, 1);
    check({tag, ".va_wr"}, valid_address, 3'b001);
    check({tag, ".wa"}, write_address, rd);
    check({tag, ".wd"}, write_data, exp);
    check({tag, ".ready_wr"}, instr_ready, 0);
    @(posedge clk); #1;
    retired = (retired + 1) % 65536;
    model[rd] = exp;
    check({tag, ".done_after"}, done, 0);
    check({tag, ".ready_after"}, instr_ready, 1);
    check({tag, ".retire"}, retire_count, retired);
    check({tag, ".rf"}, mem[rd], exp);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]   = '0;
      model[i] = '0;
    end
    read_data1  = '0;
    read_data2  = '0;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr_op    = '0;
    instr_rd    = '0;
    instr_rs    = '0;
    instr_rt    = '0;
    instr_imm   = '0;
    repeat (2) @(negedge clk);
    check("rst.ready", instr_ready, 1);
    check("rst.va", valid_address, 0);
    check("rst.done", done, 0);
    check("rst.retire", retire_count, 0);
    check("rst.wd", write_data, 0);
    check("rst.addr", {read_address1, read_address2, write_address}, 0);
    rst_n = 1'b1;

    run_instr(3'd7, 5'd1, 5'd0, 5'd0, 16'h1234, 0, "ldi_first");
    check("r1_1234", mem[1], 16'h1234);

    run_instr(3'd7, 5'd1, 5'd0, 5'd0, 16'hFFFF, 0, "ldi_r1");
    run_instr(3'd7, 5'd2, 5'd0, 5'd0, 16'h0001, 0, "ldi_r2");
    run_instr(3'd0, 5'd3, 5'd1, 5'd2, 16'h0000, 0, "add_wrap");
    check("r3_zero", mem[3], 16'h0000);
    run_instr(3'd1, 5'd4, 5'd2, 5'd1, 16'h0000, 0, "sub_borrow");
    check("r4_two", mem[4], 16'h0002);

    run_instr(3'd7, 5'd1, 5'd0, 5'd0, 16'hF0F0, 0, "ldi_f0f0");
    run_instr(3'd7, 5'd2, 5'd0, 5'd0, 16'h0FF0, 0, "ldi_0ff0");
    run_instr(3'd2, 5'd8, 5'd1, 5'd2, 16'h0000, 0, "and");
    run_instr(3'd3, 5'd9, 5'd1, 5'd2, 16'h0000, 0, "or");
    run_instr(3'd4, 5'd10, 5'd1, 5'd2, 16'h0000, 0, "xor");
    check("and_val", mem[8], 16'h00F0);
    check("or_val", mem[9], 16'hFFF0);
    check("xor_val", mem[10], 16'hFF00);

    run_instr(3'd7, 5'd1, 5'd0, 5'd0, 16'h0001, 0, "ldi_one");
    run_instr(3'd7, 5'd2, 5'd0, 5'd0, 16'h0013, 0, "ldi_13");
    run_instr(3'd5, 5'd11, 5'd1, 5'd2, 16'h0000, 0, "sll");
    check("sll_val", mem[11], 16'h0008);
    run_instr(3'd7, 5'd1, 5'd0, 5'd0, 16'h8000, 0, "ldi_8000");
    run_instr(3'd7, 5'd2, 5'd0, 5'd0, 16'h000F, 0, "ldi_f");
    run_instr(3'd6, 5'd12, 5'd1, 5'd2, 16'h0000, 0, "srl");
    check("srl_val", mem[12], 16'h0001);

    // instr_valid held high: back-to-back accepts with a dependent ADD
    run_instr(3'd7, 5'd6, 5'd0, 5'd0, 16'($urandom), 1, "hold_ldi");
    run_instr(3'd0, 5'd7, 5'd6, 5'd6, 16'h0000, 1, "hold_add");
    run_instr(3'd0, 5'd7, 5'd7, 5'd1, 16'h0000, 0, "hold_add2");

    run_instr(3'd7, 5'd0, 5'd0, 5'd0, 16'hBEEF, 0, "ldi_r0");
    check("r0_written", mem[0], 16'hBEEF);

    for (int i = 0; i < 40; i++)
      run_instr(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom),
                16'($urandom), 1'($urandom), "rand");

    // Reset in the EXEC cycle of ADD r5 drops the instruction
    run_instr(3'd7, 5'd5, 5'd0, 5'd0, 16'h5555, 0, "ldi_r5");
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op    = 3'd0;
    instr_rd    = 5'd5;
    instr_rs    = 5'd1;
    instr_rt    = 5'd2;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    check("rstx.va_exec", valid_address, 3'b000);
    #5;
    rst_n = 1'b0;
    #1;
    check("rstx.ready", instr_ready, 1);
    check("rstx.va", valid_address, 0);
    check("rstx.done", done, 0);
    check("rstx.retire", retire_count, 0);
    check("rstx.wd", write_data, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rstx.no_write", valid_address, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    retired = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rstx.post_va", valid_address, 0);
      check("rstx.post_ready", instr_ready, 1);
    end
    check("rstx.retire_after", retire_count, 0);
    check("rstx.r5_kept", mem[5], 16'h5555);

    run_instr(3'd7, 5'd13, 5'd0, 5'd0, 16'($urandom), 0, "after_rst");
    run_instr(3'd0, 5'd14, 5'd13, 5'd5, 16'h0000, 0, "after_rst_add");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_sequencer.md
# rf_sequencer

Instruction sequencer that drives the 32×16 register file: accepts one register-register (or load-immediate) instruction per handshake, reads both source operands, computes a 16-bit ALU result, and writes it back to the destination register. Sits directly upstream of the register file and owns its read-address, write-address, write-data and `valid_address` strobes. Fixed 4-cycle issue-to-writeback sequence, no overlap, so no hazard logic is needed.

## Interface
- No parameters; data width 16, address width 5 fixed.
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_valid` in 1: instruction offered.
- `instr_ready` out 1: sequencer can accept; high only in IDLE.
- `instr_op` in 3: opcode.
- `instr_rd`, `instr_rs`, `instr_rt` in 5 each: destination, source 1, source 2.
- `instr_imm` in 16: immediate, used by LDI only.
- `read_address1`, `read_address2` out 5: to register file.
- `write_address` out 5, `write_data` out 16: to register file.
- `valid_address` out 3: bit2 read port 2, bit1 read port 1, bit0 write.
- `read_data1`, `read_data2` in 16: from register file.
- `done` out 1: one-cycle pulse in the writeback cycle.
- `retire_count` out 16: instructions written back since reset, wraps 0xFFFF→0.

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 LDI.
- Arithmetic mod 2^16; carry/borrow discarded. SUB = rs − rt.
- SLL/SRL: `read_data1` shifted by `read_data2[3:0]`, zero fill.
- LDI: result = `instr_imm`. No register reads; `valid_address` = 000 in READ.
- Accept on `instr_valid && instr_ready`; op/rd/rs/rt/imm latched into internal registers at that edge. Inputs ignored outside IDLE.
- States:
  - IDLE: `instr_ready`=1; on accept → READ.
  - READ: addresses = latched rs/rt; `valid_address`=110 (000 for LDI) → EXEC.
  - EXEC: operands present on `read_data1/2`; result registered at end of cycle → WRITE.
  - WRITE: `write_address`=rd, `write_data`=result, `valid_address`=001, `done`=1; `retire_count` increments at end of cycle → IDLE.
- Writes to register 0 are performed; register 0 is not special.
- Reset (any state, including mid-instruction): immediately state IDLE and all outputs at reset values; the in-flight instruction is dropped with no write.
- Reset values: `instr_ready`=1, `valid_address`=000, addresses=0, `write_data`=0, `done`=0, `retire_count`=0.

## Timing
- Accept at edge E0. READ is cycle E0→E1; the register file samples reads at E1. EXEC is E1→E2; result is registered at E2. WRITE is E2→E3; the register file samples the write at E3. IDLE from E3.
- Throughput is one instruction per 4 cycles; `instr_ready` is low for exactly 3 cycles after accept.
- The register file updates its outputs 20 time units after the edge, so the clock period must exceed 20 time units. The bench uses a period of 40.
- Back-to-back dependency is safe: the write is sampled at E3, and the next instruction's read is sampled at E3+2 at the earliest.
- `valid_address`, addresses, `write_data` and `done` are decoded from the state and latched registers only, never from live `instr_*` inputs.

## Structure
- Shared package holds the opcode constants, the state enum (IDLE, READ, EXEC, WRITE, 2-bit encoding) and the `valid_address` bit positions.
- One sub-module, `alu16`: combinational, taking op, a and b and producing the 16-bit result. The sequencer holds the FSM, the latches and the counter.

## Test plan
- Reset then LDI r1←0x1234 → `done` at cycle 3 after accept; r1 reads back 0x1234; `retire_count`=1.
- LDI r1=0xFFFF, LDI r2=0x0001, ADD r3=r1+r2 → r3=0x0000. SUB r4=r2−r1 → r4=0x0002.
- AND/OR/XOR with r1=0xF0F0, r2=0x0FF0 → 0x00F0, 0xFFF0, 0xFF00.
- SLL r1=0x0001 by r2=0x0013 (low nibble 3) → 0x0008. SRL 0x8000 by 15 → 0x0001.
- `instr_valid` held high continuously → accepts spaced exactly 4 cycles; an immediately dependent ADD reads the new value.
- Assert `rst_n` low in EXEC of ADD r5 → no write to r5 (`valid_address` never 001), `retire_count`=0, `instr_ready`=1 after release.
